// File: rtl/apb_ram_bank_array_if.sv
// APB3 bus bundle for apb_ram_bank_array. The pstrb signal exists only when
// APB_RAM_PSTRB_EN is defined.
interface apb_ram_bank_array_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
`ifdef APB_RAM_PSTRB_EN
    logic [DATA_W/8-1:0] pstrb;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
`else
    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
`endif
endinterface

// File: rtl/apb_ram_bank_array.sv
// APB3 slave over NUM_BANKS single-port RAM banks with programmable wait states,
// registered read data and PSLVERR on out-of-range banks. Byte strobes: APB_RAM_PSTRB_EN.

// One RAM bank: async read, byte-enabled write, contents never reset.
module apb_ram_bank #(
    parameter int DATA_W = 32,
    parameter int AW     = 6
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);
    logic [DATA_W-1:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DATA_W/8; i++) begin
            if (we_i && be_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
    end

    assign rdata_o = mem_q[addr_i];
endmodule

module apb_ram_bank_array #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int BANK_AW   = 6,
    parameter int NUM_BANKS = 5,
    parameter int RD_WAIT   = 0,
    parameter int WR_WAIT   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    apb_ram_bank_array_if.slave  apb
);
    localparam int BANK_IW = ADDR_W - BANK_AW;
    localparam int STRB_W  = DATA_W / 8;
    localparam logic [BANK_IW:0] NB = (BANK_IW+1)'(NUM_BANKS);

    if (NUM_BANKS < 1 || NUM_BANKS > 2**BANK_IW || DATA_W % 8 != 0 ||
        RD_WAIT < 0 || RD_WAIT > 15 || WR_WAIT < 0 || WR_WAIT > 15) begin : g_param_err
        $error("apb_ram_bank_array: illegal parameter combination");
    end

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e                         state_q, state_d;
    logic [3:0]                     cnt_q, cnt_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic                           wr_q, wr_d;
    logic                           err_q, err_d;
    logic [DATA_W-1:0]              prdata_q, prdata_d;
    logic                           pready;
    logic                           commit;
    logic [BANK_IW-1:0]             setup_bank;
    logic                           setup_err;
    logic [BANK_AW-1:0]             ram_addr;
    logic [STRB_W-1:0]              wr_be;
    logic [NUM_BANKS-1:0]           bank_we;
    logic [NUM_BANKS-1:0][DATA_W-1:0] bank_rdata;
    logic [DATA_W-1:0]              rd_mux;

    assign setup_bank = apb.paddr[ADDR_W-1:BANK_AW];
    assign setup_err  = {1'b0, setup_bank} >= NB;

    // Single port: the live address reads during setup, the captured one writes in access.
    assign ram_addr = (state_q == IDLE) ? apb.paddr[BANK_AW-1:0] : addr_q[BANK_AW-1:0];

`ifdef APB_RAM_PSTRB_EN
    assign wr_be = apb.pstrb;
`else
    assign wr_be = '1;
`endif

    assign commit = rst_n && pready && wr_q && !err_q;

    always_comb begin
        bank_we = '0;
        rd_mux  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (commit && addr_q[ADDR_W-1:BANK_AW] == BANK_IW'(b)) bank_we[b] = 1'b1;
            if (setup_bank == BANK_IW'(b)) rd_mux = bank_rdata[b];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        apb_ram_bank #(
            .DATA_W (DATA_W),
            .AW     (BANK_AW)
        ) u_bank (
            .clk_i   (clk),
            .we_i    (bank_we[b]),
            .be_i    (wr_be),
            .addr_i  (ram_addr),
            .wdata_i (apb.pwdata),
            .rdata_o (bank_rdata[b])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        err_d    = err_q;
        prdata_d = prdata_q;
        pready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_d = ACCESS;
                    addr_d  = apb.paddr;
                    wr_d    = apb.pwrite;
                    err_d   = setup_err;
                    cnt_d   = apb.pwrite ? 4'(WR_WAIT) : 4'(RD_WAIT);
                    if (!apb.pwrite) prdata_d = setup_err ? '0 : rd_mux;
                end
            end
            ACCESS: begin
                // A dropped psel abandons the transfer without a response.
                if (!apb.psel) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    pready  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            prdata_q <= prdata_d;
        end
    end

    assign apb.pready  = pready;
    assign apb.pslverr = pready & err_q;
    assign apb.prdata  = prdata_q;
endmodule
